// File: rtl/cpu_debug_reader.sv
// ---------------------------------------------------------------------------
// cpu_debug_reader
// Walks the multi-cycle CPU's display/debug ports after a start pulse and
// streams every value out as one tagged item on a valid/ready interface:
// registers 0..31, then MEM_WORDS data-memory words, then the CPU FSM state
// captured at the moment the scan was started.
//
// Parameters
//   MEM_BASE   byte address of memory word 0 (bits [1:0] ignored)
//   MEM_WORDS  memory words per scan, 1..256
// Ports
//   i_clk            clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_start          scan request, only honoured while idle
//   o_rf_addr        regfile test-port index (combinational read)
//   i_rf_data        regfile test-port data
//   o_mem_addr       data-RAM display-port byte address (1-cycle read)
//   i_mem_data       data-RAM display-port data
//   i_display_state  CPU FSM state word
//   o_out_valid      item available
//   i_out_ready      consumer accepts the item
//   o_out_kind       0 = register, 1 = memory, 2 = state
//   o_out_index      register number / memory word index / 0
//   o_out_data       item value
//   o_busy           scan in progress (through the DONE cycle)
//   o_done           one-cycle pulse after the last item transfers
// ---------------------------------------------------------------------------
module cpu_debug_reader #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [4:0]  o_rf_addr,
  input  logic [31:0] i_rf_data,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [31:0] i_display_state,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [1:0]  o_out_kind,
  output logic [7:0]  o_out_index,
  output logic [31:0] o_out_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [31:0] BASE_ALIGNED = {MEM_BASE[31:2], 2'b00};
  localparam logic [7:0]  LAST_MEM_IDX = 8'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RF_ADDR, S_MEM_ADDR, S_MEM_WAIT, S_PRESENT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_RF, PH_MEM, PH_STATE
  } phase_t;

  state_t      r_state, w_state_next;
  phase_t      r_phase, w_phase_next;
  logic [7:0]  r_idx, w_idx_next;
  logic [31:0] r_shadow, w_shadow_next;
  logic [1:0]  r_kind, w_kind_next;
  logic [7:0]  r_index, w_index_next;
  logic [31:0] r_data, w_data_next;
  logic        w_xfer;

  // Both debug addresses follow idx directly. idx is stable through
  // MEM_ADDR/MEM_WAIT/PRESENT, so mem_addr is held while the synchronous RAM
  // port answers, and reset (idx=0) gives rf_addr=0 and mem_addr=base.
  // The 32-bit add wraps naturally past 32'hFFFF_FFFC.
  assign o_rf_addr   = r_idx[4:0];
  assign o_mem_addr  = BASE_ALIGNED + {22'd0, r_idx, 2'b00};

  assign o_out_valid = (r_state == S_PRESENT);
  assign o_out_kind  = r_kind;
  assign o_out_index = r_index;
  assign o_out_data  = r_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

  assign w_xfer      = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_phase  <= PH_RF;
      r_idx    <= 8'd0;
      r_shadow <= 32'd0;
      r_kind   <= 2'd0;
      r_index  <= 8'd0;
      r_data   <= 32'd0;
    end else begin
      r_state  <= w_state_next;
      r_phase  <= w_phase_next;
      r_idx    <= w_idx_next;
      r_shadow <= w_shadow_next;
      r_kind   <= w_kind_next;
      r_index  <= w_index_next;
      r_data   <= w_data_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_phase_next  = r_phase;
    w_idx_next    = r_idx;
    w_shadow_next = r_shadow;
    w_kind_next   = r_kind;
    w_index_next  = r_index;
    w_data_next   = r_data;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // The state item reports the CPU state at scan start, not at the end.
          w_shadow_next = i_display_state;
          w_idx_next    = 8'd0;
          w_phase_next  = PH_RF;
          w_state_next  = S_RF_ADDR;
        end
      end

      S_RF_ADDR: begin
        w_data_next  = i_rf_data;
        w_kind_next  = 2'd0;
        w_index_next = r_idx;
        w_state_next = S_PRESENT;
      end

      S_MEM_ADDR: begin
        w_state_next = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        w_data_next  = i_mem_data;
        w_kind_next  = 2'd1;
        w_index_next = r_idx;
        w_state_next = S_PRESENT;
      end

      S_PRESENT: begin
        if (w_xfer) begin
          case (r_phase)
            PH_RF: begin
              if (r_idx == 8'd31) begin
                w_idx_next   = 8'd0;
                w_phase_next = PH_MEM;
                w_state_next = S_MEM_ADDR;
              end else begin
                w_idx_next   = r_idx + 8'd1;
                w_state_next = S_RF_ADDR;
              end
            end
            PH_MEM: begin
              if (r_idx == LAST_MEM_IDX) begin
                // State item needs no port access: load it and stay presenting.
                w_kind_next  = 2'd2;
                w_index_next = 8'd0;
                w_data_next  = r_shadow;
                w_phase_next = PH_STATE;
              end else begin
                w_idx_next   = r_idx + 8'd1;
                w_state_next = S_MEM_ADDR;
              end
            end
            default: begin
              w_state_next = S_DONE;
            end
          endcase
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_debug_reader.sv
module tb_cpu_debug_reader;

  logic        clk = 1'b0;
  logic        reset;
  // main instance: MEM_BASE=0, MEM_WORDS=16
  logic        start, ready;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, mem_addr, mem_data, display_state, out_data;
  logic        valid, busy, done;
  logic [1:0]  kind;
  logic [7:0]  index;
  // wrap instance: MEM_BASE=FFFF_FFF9, MEM_WORDS=4
  logic        start_w, ready_w;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w, mem_addr_w, mem_data_w, out_data_w;
  logic        valid_w, busy_w, done_w;
  logic [1:0]  kind_w;
  logic [7:0]  index_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_debug_reader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_rf_addr(rf_addr), .i_rf_data(rf_data),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .i_display_state(display_state),
    .o_out_valid(valid), .i_out_ready(ready),
    .o_out_kind(kind), .o_out_index(index), .o_out_data(out_data),
    .o_busy(busy), .o_done(done)
  );

  cpu_debug_reader #(.MEM_BASE(32'hFFFF_FFF9), .MEM_WORDS(4)) dut_w (
    .i_clk(clk), .i_reset(reset), .i_start(start_w),
    .o_rf_addr(rf_addr_w), .i_rf_data(rf_data_w),
    .o_mem_addr(mem_addr_w), .i_mem_data(mem_data_w),
    .i_display_state(32'd7),
    .o_out_valid(valid_w), .i_out_ready(ready_w),
    .o_out_kind(kind_w), .o_out_index(index_w), .o_out_data(out_data_w),
    .o_busy(busy_w), .o_done(done_w)
  );

  // CPU port models: combinational regfile, synchronous RAM
  assign rf_data   = 32'(rf_addr) * 32'h11;
  assign rf_data_w = 32'(rf_addr_w) * 32'h11;
  always @(posedge clk) begin
    mem_data   <= 32'hA000_0000 + (mem_addr >> 2);
    mem_data_w <= mem_addr_w ^ 32'h5555_5555;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_kind(input int k, input int words);
    if (k < 32) return 2'd0;
    if (k < 32 + words) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [7:0] exp_index(input int k, input int words);
    if (k < 32) return 8'(k);
    if (k < 32 + words) return 8'(k - 32);
    return 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full scan on the main instance. n counts cycles: n=1 is the RF_ADDR cycle
  // right after the edge that samples start. Stray start pulses and a
  // display_state change are injected mid-scan; neither may affect the output.
  task automatic scan(input bit rand_ready, input string name);
    int n, item, stalls, done_n;
    logic [31:0] exp_data;
    display_state = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1; item = 0; stalls = 0; done_n = 0;
    check({name, "_busy_start"}, busy, 1);
    check({name, "_valid_rfaddr"}, valid, 0);
    while (n < 600 && done_n == 0) begin
      if (n == 10) display_state = 32'd5;
      start = (n == 20 || n == 80);
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        done_n = n;
      end else if (valid) begin
        if (item < 49) begin
          if (item < 32)      exp_data = 32'(item) * 32'h11;
          else if (item < 48) exp_data = 32'hA000_0000 + 32'(item - 32);
          else                exp_data = 32'd3;
          check({name, "_kind"},  kind,     exp_kind(item, 16));
          check({name, "_index"}, index,    exp_index(item, 16));
          check({name, "_data"},  out_data, exp_data);
        end else begin
          check({name, "_extra_item"}, item, 48);
        end
        if (ready) item++; else stalls++;
      end
      tick();
      n++;
    end
    start = 1'b0;
    ready = 1'b1;
    check({name, "_done_seen"}, done_n != 0, 1);
    check({name, "_items"}, item, 49);
    check({name, "_done_cycle"}, done_n, 114 + stalls);
    for (int i = 0; i < 5; i++) begin
      check({name, "_no_second_done"}, done, 0);
      check({name, "_idle_busy"}, busy, 0);
      tick();
    end
    display_state = 32'd3;
    $display("scan %s: %0d items, %0d stalls, done at cycle T+%0d", name, item, stalls, done_n);
  endtask

  // Scan on the wrapping instance: memory addresses cross 2^32.
  task automatic scan_w();
    logic [31:0] addr_tab [4];
    logic [31:0] data_tab [4];
    int n, item, done_n;
    addr_tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    data_tab = '{32'hAAAA_AAAD, 32'hAAAA_AAA9, 32'h5555_5555, 32'h5555_5551};
    ready_w = 1'b1;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    n = 1; item = 0; done_n = 0;
    while (n < 300 && done_n == 0) begin
      if (done_w) begin
        done_n = n;
      end else if (valid_w) begin
        if (item >= 32 && item < 36) begin
          check("wrap_kind",     kind_w,     1);
          check("wrap_index",    index_w,    8'(item - 32));
          check("wrap_mem_addr", mem_addr_w, addr_tab[item - 32]);
          check("wrap_data",     out_data_w, data_tab[item - 32]);
        end else if (item == 36) begin
          check("wrap_state_kind", kind_w, 2);
          check("wrap_state_data", out_data_w, 32'd7);
        end else if (item < 32) begin
          check("wrap_rf_data", out_data_w, 32'(item) * 32'h11);
        end
        item++;
      end
      tick();
      n++;
    end
    check("wrap_items", item, 37);
    check("wrap_done_cycle", done_n, 78);
    $display("scan wrap: %0d items, done at cycle T+%0d", item, done_n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; ready = 1'b1; start_w = 1'b0; ready_w = 1'b1;
    display_state = 32'd3;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid",    valid,      0);
    check("rst_busy",     busy,       0);
    check("rst_done",     done,       0);
    check("rst_kind",     kind,       0);
    check("rst_index",    index,      0);
    check("rst_data",     out_data,   0);
    check("rst_rf_addr",  rf_addr,    0);
    check("rst_mem_addr", mem_addr,   0);
    check("rst_mem_addr_w", mem_addr_w, 32'hFFFF_FFF8);
    $display("reset: outputs checked");

    scan(1'b0, "full");
    scan(1'b1, "random");

    // Abort a scan with reset while in MEM_WAIT of memory word 1 (cycle T+69).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 69; n++) tick();
    check("abort_mem_addr", mem_addr, 32'd4);
    check("abort_valid_wait", valid, 0);
    #2 reset = 1'b1;
    #1;
    check("abort_valid",    valid,    0);
    check("abort_busy",     busy,     0);
    check("abort_done",     done,     0);
    check("abort_kind",     kind,     0);
    check("abort_index",    index,    0);
    check("abort_data",     out_data, 0);
    check("abort_rf_addr",  rf_addr,  0);
    check("abort_mem_addr_rst", mem_addr, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", done, 0);
      tick();
    end
    $display("reset: scan aborted in MEM_WAIT");
    scan(1'b0, "after_reset");

    scan_w();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
